// File: rtl/cp_pkg.sv
// -----------------------------------------------------------------------------
// cp_pkg
// Shared definitions for the coprocessor bridge: FSM state encoding, width of
// the unit-select field, default timeout and the timeout counter width helper.
// -----------------------------------------------------------------------------
package cp_pkg;

  // Width of the dispatcher unit-select field (up to four units).
  localparam int CP_SEL_W = 2;

  // Default request-to-completion budget in clock cycles.
  localparam int CP_TIMEOUT_DEFAULT = 256;

  // Bridge FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } cp_state_t;

  // Counter width able to hold 0..cycles-1; never narrower than one bit.
  function automatic int cp_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage : cp_pkg

// File: rtl/cp_timeout_counter.sv
// -----------------------------------------------------------------------------
// cp_timeout_counter
// Saturating cycle counter used to bound how long the bridge waits on a unit.
//
// Ports:
//   clk       in  clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   clr_i     in  synchronous clear (wins over enable)
//   en_i      in  count enable
//   expired_o out high once the count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module cp_timeout_counter
  import cp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = CP_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int               CNT_W = cp_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             expired_q;
  logic             expired_d;

  // Next count: clear, count up to LAST and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    // Registered flag tracks the count it will sit next to.
    expired_d = (cnt_d == LAST);
  end

  // Counter and expiry flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule : cp_timeout_counter

// File: rtl/cp_bridge.sv
// -----------------------------------------------------------------------------
// cp_bridge
// Routes one dispatched coprocessor instruction at a time to one of CP_NUM
// units over a valid/ready request channel, waits for that unit's response
// and returns a one-cycle cp_ready strobe with result and exception flag.
// Bad selects, unresponsive units (timeout) and dispatcher aborts are handled.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cp_valid          dispatcher request, held until cp_ready unless aborted
//   cp_instruction    instruction word
//   cp_data_in        rs1 operand
//   cp_select         target unit index
//   cp_data_out       result, meaningful only while cp_ready
//   cp_ready          one-cycle completion strobe
//   cp_exception      error flag, qualified by cp_ready
//   cp_busy           high whenever the FSM is not idle
//   cpu_req_valid     one-hot request valid towards the units
//   cpu_req_inst      shared request instruction
//   cpu_req_data      shared request operand
//   cpu_req_ready     per-unit request accept
//   cpu_rsp_valid     per-unit response strobe
//   cpu_rsp_data      packed responses, unit i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cpu_rsp_error     per-unit error, qualified by cpu_rsp_valid
// All outputs are registered.
// -----------------------------------------------------------------------------
module cp_bridge
  import cp_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int INST_WIDTH     = 32,
  parameter int CP_NUM         = 3,
  parameter int TIMEOUT_CYCLES = CP_TIMEOUT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cp_valid,
  input  logic [INST_WIDTH-1:0]        cp_instruction,
  input  logic [DATA_WIDTH-1:0]        cp_data_in,
  input  logic [CP_SEL_W-1:0]          cp_select,
  output logic [DATA_WIDTH-1:0]        cp_data_out,
  output logic                         cp_ready,
  output logic                         cp_exception,
  output logic                         cp_busy,
  output logic [CP_NUM-1:0]            cpu_req_valid,
  output logic [INST_WIDTH-1:0]        cpu_req_inst,
  output logic [DATA_WIDTH-1:0]        cpu_req_data,
  input  logic [CP_NUM-1:0]            cpu_req_ready,
  input  logic [CP_NUM-1:0]            cpu_rsp_valid,
  input  logic [CP_NUM*DATA_WIDTH-1:0] cpu_rsp_data,
  input  logic [CP_NUM-1:0]            cpu_rsp_error
);

  localparam int                UNITS_MAX = 1 << CP_SEL_W;
  localparam logic [CP_SEL_W:0] CP_NUM_L  = (CP_SEL_W + 1)'(CP_NUM);

  cp_state_t             state_q, state_d;
  logic                  hs_done_q, hs_done_d;
  logic [CP_SEL_W-1:0]   sel_q, sel_d;
  logic                  cp_ready_q, cp_ready_d;
  logic                  cp_exception_q, cp_exception_d;
  logic [DATA_WIDTH-1:0] cp_data_out_q, cp_data_out_d;
  logic                  cp_busy_q, cp_busy_d;
  logic [CP_NUM-1:0]     req_valid_q, req_valid_d;
  logic [INST_WIDTH-1:0] req_inst_q, req_inst_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;

  logic [UNITS_MAX-1:0]  req_ready_pad_s;
  logic [UNITS_MAX-1:0]  rsp_valid_pad_s;
  logic [UNITS_MAX-1:0]  rsp_error_pad_s;
  logic [DATA_WIDTH-1:0] rsp_data_sel_s;
  logic                  req_ready_sel_s;
  logic                  rsp_valid_sel_s;
  logic                  rsp_error_sel_s;
  logic                  sel_ok_s;
  logic                  expired_s;
  logic                  cnt_clr_s;
  logic                  cnt_en_s;
  logic                  accept_s;
  logic                  req_drive_s;
  logic [CP_SEL_W-1:0]   tgt_sel_s;

  // Widen per-unit inputs to the full select range so an index of sel_q is
  // always in bounds, and pick the selected unit's response data (AND-OR mux).
  always_comb begin
    req_ready_pad_s = '0;
    rsp_valid_pad_s = '0;
    rsp_error_pad_s = '0;
    rsp_data_sel_s  = '0;
    for (int i = 0; i < CP_NUM; i++) begin
      req_ready_pad_s[i] = cpu_req_ready[i];
      rsp_valid_pad_s[i] = cpu_rsp_valid[i];
      rsp_error_pad_s[i] = cpu_rsp_error[i];
      rsp_data_sel_s     = rsp_data_sel_s |
                           ({DATA_WIDTH{sel_q == CP_SEL_W'(i)}} &
                            cpu_rsp_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  assign req_ready_sel_s = req_ready_pad_s[sel_q];
  assign rsp_valid_sel_s = rsp_valid_pad_s[sel_q];
  assign rsp_error_sel_s = rsp_error_pad_s[sel_q];
  assign sel_ok_s        = ({1'b0, cp_select} < CP_NUM_L);
  assign accept_s        = (state_q == ST_IDLE) && cp_valid;

  // Counter is held clear while idle, so it starts from zero on ISSUE entry.
  assign cnt_clr_s = (state_q == ST_IDLE);
  assign cnt_en_s  = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                     (state_q == ST_DRAIN);

  cp_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr_s),
    .en_i      (cnt_en_s),
    .expired_o (expired_s)
  );

  // FSM state and handshake-done flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hs_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hs_done_q <= hs_done_d;
    end
  end

  // Next-state logic. An abort takes precedence over a timeout so an aborted
  // request never produces cp_ready; a response beats a coincident timeout.
  always_comb begin
    state_d   = state_q;
    hs_done_d = hs_done_q;
    case (state_q)
      ST_IDLE: begin
        hs_done_d = 1'b0;
        if (cp_valid) begin
          state_d = sel_ok_s ? ST_ISSUE : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!cp_valid) begin
          state_d   = ST_DRAIN;
          hs_done_d = req_ready_sel_s;
        end else if (expired_s) begin
          state_d = ST_DONE;
        end else if (req_ready_sel_s) begin
          state_d   = ST_WAIT;
          hs_done_d = 1'b1;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (rsp_valid_sel_s) begin
          // Response arriving in the abort cycle is simply discarded.
          state_d = cp_valid ? ST_DONE : ST_IDLE;
        end else if (!cp_valid) begin
          state_d = ST_DRAIN;
        end else if (expired_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (expired_s) begin
          state_d = ST_IDLE;
        end else if (!hs_done_q) begin
          // Responses are only meaningful once the request was accepted.
          hs_done_d = req_ready_sel_s;
        end else if (rsp_valid_sel_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        hs_done_d = 1'b0;
      end
    endcase
  end

  // Output next-values, derived from the transition being taken.
  always_comb begin
    // Request valid stays up while issuing, and while draining an abort that
    // has not yet been accepted by the unit.
    req_drive_s = (state_d == ST_ISSUE) ||
                  ((state_d == ST_DRAIN) && !hs_done_d);
    tgt_sel_s   = (state_q == ST_IDLE) ? cp_select : sel_q;
    req_valid_d = '0;
    for (int i = 0; i < CP_NUM; i++) begin
      req_valid_d[i] = req_drive_s && (tgt_sel_s == CP_SEL_W'(i));
    end

    sel_d      = accept_s ? cp_select      : sel_q;
    req_inst_d = accept_s ? cp_instruction : req_inst_q;
    req_data_d = accept_s ? cp_data_in     : req_data_q;

    cp_ready_d = (state_d == ST_DONE);
    cp_busy_d  = (state_d != ST_IDLE);
    if ((state_d == ST_DONE) && (state_q == ST_WAIT) && rsp_valid_sel_s) begin
      cp_data_out_d  = rsp_data_sel_s;
      cp_exception_d = rsp_error_sel_s;
    end else if (state_d == ST_DONE) begin
      // Bad select or timeout: flag error with a cleared result.
      cp_data_out_d  = '0;
      cp_exception_d = 1'b1;
    end else begin
      cp_data_out_d  = '0;
      cp_exception_d = 1'b0;
    end
  end

  // Output and request-latch registers; reset drops request valids at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q          <= '0;
      cp_ready_q     <= 1'b0;
      cp_exception_q <= 1'b0;
      cp_data_out_q  <= '0;
      cp_busy_q      <= 1'b0;
      req_valid_q    <= '0;
      req_inst_q     <= '0;
      req_data_q     <= '0;
    end else begin
      sel_q          <= sel_d;
      cp_ready_q     <= cp_ready_d;
      cp_exception_q <= cp_exception_d;
      cp_data_out_q  <= cp_data_out_d;
      cp_busy_q      <= cp_busy_d;
      req_valid_q    <= req_valid_d;
      req_inst_q     <= req_inst_d;
      req_data_q     <= req_data_d;
    end
  end

  assign cp_ready      = cp_ready_q;
  assign cp_exception  = cp_exception_q;
  assign cp_data_out   = cp_data_out_q;
  assign cp_busy       = cp_busy_q;
  assign cpu_req_valid = req_valid_q;
  assign cpu_req_inst  = req_inst_q;
  assign cpu_req_data  = req_data_q;

endmodule : cp_bridge

// File: doc/cp_bridge.md
# cp_bridge

Sequential bridge between the coprocessor dispatcher and the physical coprocessor units. Accepts one dispatched coprocessor instruction at a time and routes it to one of `CP_NUM` units using a valid/ready request channel. Waits for that unit's response, then returns a one-cycle `cp_ready` strobe with the result and an exception flag to the dispatcher. Also handles bad unit selects, unresponsive units (timeout) and pipeline aborts.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `INST_WIDTH`, 32, instruction width
- `CP_NUM`, 3, number of attached units (1..4)
- `TIMEOUT_CYCLES`, 256, max cycles from request issue to completion

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `cp_valid` in 1: dispatcher request; held high until `cp_ready` unless the pipeline aborts
- `cp_instruction` in INST_WIDTH: instruction word
- `cp_data_in` in DATA_WIDTH: rs1 operand
- `cp_select` in 2: target unit index
- `cp_data_out` out DATA_WIDTH: result, valid only while `cp_ready`=1
- `cp_ready` out 1: one-cycle completion strobe
- `cp_exception` out 1: error flag, qualified by `cp_ready`
- `cp_busy` out 1: high in any state other than IDLE
- `cpu_req_valid` out CP_NUM: one-hot request valid
- `cpu_req_inst` out INST_WIDTH: shared request instruction (registered)
- `cpu_req_data` out DATA_WIDTH: shared request operand (registered)
- `cpu_req_ready` in CP_NUM: per-unit request accept
- `cpu_rsp_valid` in CP_NUM: per-unit response strobe
- `cpu_rsp_data` in CP_NUM*DATA_WIDTH: packed responses; unit i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `cpu_rsp_error` in CP_NUM: per-unit error, qualified by `cpu_rsp_valid`

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE, DRAIN.
- **IDLE**, on `cp_valid`:
  - Latch instruction, operand and select.
  - If select ≥ CP_NUM: set error, clear result → DONE.
  - Otherwise → ISSUE.
- **ISSUE**:
  - `cpu_req_valid[sel]`=1, all other bits 0.
  - On `cpu_req_ready[sel]` (handshake) → WAIT.
- **WAIT**:
  - On `cpu_rsp_valid[sel]`, latch `cpu_rsp_data` slice and `cpu_rsp_error[sel]` → DONE.
  - Handshake and response may not coincide: a response is sampled only in WAIT.
- **DONE**:
  - `cp_ready`=1 for exactly one cycle, with `cp_data_out` and `cp_exception` driven from the latches → IDLE.
  - A new `cp_valid` is accepted in the following cycle.
- **Timeout**:
  - Counter clears on entry to ISSUE and increments every cycle in ISSUE, WAIT and DRAIN.
  - Reaching TIMEOUT_CYCLES-1 without completion, in ISSUE or WAIT: drop `cpu_req_valid`, set error, clear result → DONE.
  - Reaching it in DRAIN: → IDLE.
- **Abort** (`cp_valid`=0 while in ISSUE or WAIT) → DRAIN:
  - If the handshake is not yet done, keep `cpu_req_valid` asserted until it is.
  - Then wait for `cpu_rsp_valid[sel]` and discard the response → IDLE.
  - `cp_ready` is never asserted for an aborted request.
- **Stray input**: responses from a non-selected unit, and responses outside WAIT/DRAIN, are ignored.
- `cpu_req_inst` and `cpu_req_data` hold the latched values from IDLE exit until the next accept.

## Timing
- Reset value of every output: 0. FSM resets to IDLE; latches and counter clear.
- Best-case latency:
  - `cp_valid` sampled at edge T0.
  - `cpu_req_valid` high in cycle T1; `cpu_req_ready` in T1.
  - `cpu_rsp_valid` in T2.
  - `cp_ready` in T3: 3 cycles.
- Bad select: `cp_ready` with `cp_exception`=1 in T1.
- Timeout: `cp_ready` with `cp_exception`=1 exactly TIMEOUT_CYCLES+1 cycles after T0.
- All outputs are registered; there is no combinational path from `cpu_*` inputs to `cp_*` outputs.
- `rst_n` asserted mid-transaction: immediate return to IDLE, all request valids drop asynchronously, and no response is returned.

## Structure
- Shared package `cp_pkg`:
  - `cp_state_t` enum (IDLE, ISSUE, WAIT, DONE, DRAIN).
  - `CP_SEL_W`=2.
  - Default `TIMEOUT_CYCLES`.
- One sub-module, `cp_timeout_counter`:
  - Clear/enable inputs and an `expired` output.
  - Width $clog2(TIMEOUT_CYCLES).

## Test plan
- Select 1; unit 1 accepts in T1 and responds in T2 with 0xDEADBEEF, error 0 → `cp_ready` in T3, `cp_data_out`=0xDEADBEEF, `cp_exception`=0, `cpu_req_valid`=3'b010 during T1 only.
- Select 3 with CP_NUM=3 → `cp_ready`=1 and `cp_exception`=1 in T1, `cp_data_out`=0, no `cpu_req_valid` ever asserted.
- Unit 0 holds `cpu_req_ready` low for 4 cycles, then responds with error=1, data 0x5 → `cpu_req_valid[0]` held stable for 5 cycles; `cp_ready` with `cp_exception`=1, data 0x5.
- TIMEOUT_CYCLES=16, unit 2 never responds → `cp_ready` and `cp_exception` in cycle T0+17, `cp_data_out`=0; a later stray rsp from unit 2 in IDLE is ignored.
- `cp_valid` dropped in WAIT; unit responds 3 cycles later → no `cp_ready`, `cp_busy` falls the cycle after the response; a back-to-back new request completes normally.
- `rst_n` pulsed low while in ISSUE → all outputs 0 immediately; the first request after release completes in 3 cycles.
